// File: rtl/set_seq_pkg.sv
// Shared state encoding for the clock/alarm setting sequencer and its display logic.
// The numeric state code is what the mode output carries.
package set_seq_pkg;

    typedef enum logic [3:0] {
        StRun   = 4'd0,
        StTMin  = 4'd1,
        StTHrs  = 4'd2,
        StTDay  = 4'd3,
        StTDate = 4'd4,
        StTMon  = 4'd5,
        StAMin  = 4'd6,
        StAHrs  = 4'd7,
        StADay  = 4'd8
    } state_t;

    // Strobe bit order: {mon, date, day, hrs, min}
    localparam int unsigned NumFields = 5;

    function automatic logic is_time(state_t s);
        return (s >= StTMin) && (s <= StTMon);
    endfunction

    function automatic logic is_alarm(state_t s);
        return (s >= StAMin) && (s <= StADay);
    endfunction

    function automatic state_t next_state(state_t s);
        return (s == StADay) ? StRun : state_t'(s + 4'd1);
    endfunction

    function automatic logic [NumFields-1:0] field_strobe(state_t s);
        logic [NumFields-1:0] f;
        f = '0;
        case (s)
            StTMin, StAMin: f = 5'b00001;
            StTHrs, StAHrs: f = 5'b00010;
            StTDay, StADay: f = 5'b00100;
            StTDate:        f = 5'b01000;
            StTMon:         f = 5'b10000;
            default:        f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/set_seq_btn_db.sv
// Two-flop synchronizer followed by a debouncer: the level follows the synchronized
// input only after it has disagreed for DB consecutive cycles.
module btn_db #(
    parameter int unsigned DB = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = $clog2(DB + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/set_seq.sv
// Mode/advance button sequencer for setting time and alarm fields, with
// press-and-hold auto-repeat and an idle timeout back to RUN.
module set_seq
    import set_seq_pkg::*;
#(
    parameter int unsigned DB   = 3,
    parameter int unsigned HOLD = 2,
    parameter int unsigned TO   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       adv_btn,
    output logic       timeset,
    output logic       alarmset,
    output logic       minadv,
    output logic       hrsadv,
    output logic       dayadv,
    output logic       datadv,
    output logic       monadv,
    output logic [3:0] mode
);

    localparam int unsigned HW = $clog2(HOLD + 2);
    localparam int unsigned IW = $clog2(TO + 2);

    logic mode_lvl, adv_lvl, mode_lvl_q, adv_lvl_q;
    logic mode_rise, adv_rise, setting;

    state_t                 state_q, state_d;
    logic                   armed_q, armed_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic [NumFields-1:0]   strobe_q, strobe_d;
    logic                   timeset_q, alarmset_q;

    btn_db #(.DB(DB)) u_mode_db (.clk(clk), .rst(rst), .raw(mode_btn), .level(mode_lvl));
    btn_db #(.DB(DB)) u_adv_db  (.clk(clk), .rst(rst), .raw(adv_btn),  .level(adv_lvl));

    assign mode_rise = mode_lvl & ~mode_lvl_q;
    assign adv_rise  = adv_lvl & ~adv_lvl_q;
    assign setting   = (state_q != StRun);

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        hold_d   = hold_q;
        idle_d   = '0;
        strobe_d = '0;

        // armed marks a press that began in the current field; only it may repeat
        if (mode_rise) begin
            state_d = next_state(state_q);
            armed_d = 1'b0;
            hold_d  = '0;
        end else if (setting && adv_rise) begin
            armed_d  = 1'b1;
            hold_d   = '0;
            strobe_d = field_strobe(state_q);
        end else if (armed_q && adv_lvl) begin
            hold_d = (hold_q == HW'(HOLD)) ? hold_q : hold_q + HW'(1);
            if (hold_d == HW'(HOLD)) begin
                strobe_d = field_strobe(state_q);
            end
        end else begin
            armed_d = 1'b0;
            hold_d  = '0;
        end

        if (setting && !mode_lvl && !adv_lvl) begin
            idle_d = (idle_q == IW'(TO)) ? idle_q : idle_q + IW'(1);
            if (idle_d == IW'(TO)) begin
                state_d = StRun;
                armed_d = 1'b0;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_lvl_q <= 1'b0;
            adv_lvl_q  <= 1'b0;
            state_q    <= StRun;
            armed_q    <= 1'b0;
            hold_q     <= '0;
            idle_q     <= '0;
            strobe_q   <= '0;
            timeset_q  <= 1'b0;
            alarmset_q <= 1'b0;
        end else begin
            mode_lvl_q <= mode_lvl;
            adv_lvl_q  <= adv_lvl;
            state_q    <= state_d;
            armed_q    <= armed_d;
            hold_q     <= hold_d;
            idle_q     <= idle_d;
            strobe_q   <= strobe_d;
            timeset_q  <= is_time(state_d);
            alarmset_q <= is_alarm(state_d);
        end
    end

    assign mode     = state_q;
    assign timeset  = timeset_q;
    assign alarmset = alarmset_q;
    assign minadv   = strobe_q[0];
    assign hrsadv   = strobe_q[1];
    assign dayadv   = strobe_q[2];
    assign datadv   = strobe_q[3];
    assign monadv   = strobe_q[4];

endmodule

// File: tb/tb_set_seq.sv
// Bench for set_seq: directed scenarios plus random button activity, every cycle
// compared against a press/timeline reference model.
module tb_set_seq;

    localparam int unsigned DB   = 3;
    localparam int unsigned HOLD = 2;
    localparam int unsigned TO   = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       adv_btn = 1'b0;
    logic       timeset, alarmset, minadv, hrsadv, dayadv, datadv, monadv;
    logic [3:0] mode;
    logic [4:0] stb;

    set_seq #(.DB(DB), .HOLD(HOLD), .TO(TO)) dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .adv_btn(adv_btn),
        .timeset(timeset), .alarmset(alarmset), .minadv(minadv), .hrsadv(hrsadv),
        .dayadv(dayadv), .datadv(datadv), .monadv(monadv), .mode(mode)
    );

    assign stb = {monadv, datadv, dayadv, hrsadv, minadv};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: raw sample history, debounced levels, press start and last busy cycle
    int         n = 0;
    int         st = 0;
    int         press = -1;
    int         last_busy = 0;
    bit         lm_cur, lm_prev, la_cur, la_prev;
    bit         hist_m[$];
    bit         hist_a[$];
    logic [3:0] exp_mode;
    logic       exp_ts, exp_as;
    logic [4:0] exp_stb;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] field(input int s);
        case (s)
            1, 6:    return 5'b00001;
            2, 7:    return 5'b00010;
            3, 8:    return 5'b00100;
            4:       return 5'b01000;
            5:       return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    // Level flips once the last DB synchronized samples (two cycles old) all disagree
    function automatic bit debounce(input bit q[$], input bit cur);
        for (int i = 2; i < int'(DB) + 2; i++) if (q[i] == cur) return cur;
        return !cur;
    endfunction

    task automatic model_reset();
        st = 0; press = -1; last_busy = n;
        lm_cur = 0; lm_prev = 0; la_cur = 0; la_prev = 0;
        hist_m = {}; hist_a = {};
        for (int i = 0; i < int'(DB) + 2; i++) begin
            hist_m.push_back(1'b0);
            hist_a.push_back(1'b0);
        end
        exp_mode = 4'd0; exp_ts = 1'b0; exp_as = 1'b0; exp_stb = 5'd0;
    endtask

    task automatic model_step();
        bit mr, ar, new_m, new_a;
        int nst;
        logic [4:0] s;
        hist_m.push_front(mode_btn);
        hist_a.push_front(adv_btn);
        while (hist_m.size() > int'(DB) + 2) void'(hist_m.pop_back());
        while (hist_a.size() > int'(DB) + 2) void'(hist_a.pop_back());
        new_m = debounce(hist_m, lm_cur);
        new_a = debounce(hist_a, la_cur);
        mr = lm_cur && !lm_prev;
        ar = la_cur && !la_prev;
        nst = st;
        s = 5'd0;
        if (mr) begin
            nst = (st + 1) % 9;
            press = -1;
        end else if (st != 0) begin
            if (ar) begin
                press = n;
                s = field(st);
            end else if (press >= 0 && la_cur && (n - press) >= int'(HOLD)) begin
                s = field(st);
            end
            if (!la_cur) press = -1;
        end
        if (st == 0 || lm_cur || la_cur) last_busy = n;
        else if (n - last_busy >= int'(TO)) begin
            nst = 0;
            press = -1;
        end
        lm_prev = lm_cur; lm_cur = new_m;
        la_prev = la_cur; la_cur = new_a;
        st = nst;
        exp_mode = 4'(nst);
        exp_ts = (nst >= 1 && nst <= 5);
        exp_as = (nst >= 6 && nst <= 8);
        exp_stb = s;
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (rst) model_reset();
        else model_step();
        #1;
        check("mode", 8'(mode), 8'(exp_mode));
        check("timeset", 8'(timeset), 8'(exp_ts));
        check("alarmset", 8'(alarmset), 8'(exp_as));
        check("strobes", 8'(stb), 8'(exp_stb));
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic goto_state(input int target);
        mode_btn = 1'b0;
        adv_btn = 1'b0;
        ticks(8);
        for (int k = 0; k < 12 && st != target; k++) begin
            mode_btn = 1'b1;
            ticks(4);
            mode_btn = 1'b0;
            ticks(6);
        end
    endtask

    initial begin
        int first;
        logic [4:0] acc;
        logic h7;

        model_reset();
        #1;
        check("reset_mode", 8'(mode), 8'd0);
        check("reset_outs", 8'({timeset, alarmset, stb}), 8'd0);
        ticks(2);
        rst = 1'b0;

        // Mode press from RUN: T_MIN six cycles after the raw rise, no strobes
        mode_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) check("mode_lat5", 8'(mode), 8'd0);
            if (i == 6) begin
                check("mode_lat6", 8'(mode), 8'd1);
                check("timeset_lat6", 8'(timeset), 8'd1);
            end
        end
        mode_btn = 1'b0;
        ticks(8);

        // 4-cycle adv pulse in T_HRS: first hrsadv six cycles after the rise, gap before repeat
        goto_state(2);
        adv_btn = 1'b1;
        first = -1;
        h7 = 1'bx;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (hrsadv === 1'b1 && first < 0) first = i;
            if (i == 7) h7 = hrsadv;
            if (i == 4) adv_btn = 1'b0;
        end
        check("hrs_first", 8'(first), 8'd6);
        check("hrs_gap7", 8'(h7), 8'd0);
        ticks(8);

        // Press into T_MON, 2-cycle adv glitch, then timeout TO cycles after the mode level drops
        goto_state(4);
        mode_btn = 1'b1;
        acc = 5'd0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            acc |= stb;
            if (i == 5) mode_btn = 1'b0;
            if (i == 12) adv_btn = 1'b1;
            if (i == 14) adv_btn = 1'b0;
            if (i == 6) check("tmon_enter", 8'(mode), 8'd5);
            if (i == 39) check("tmon_before_to", 8'(mode), 8'd5);
            if (i == 40) begin
                check("timeout_mode", 8'(mode), 8'd0);
                check("timeout_timeset", 8'(timeset), 8'd0);
            end
        end
        check("glitch_no_strobe", 8'(acc), 8'd0);

        // Simultaneous mode and adv rise in T_MIN: advance, no strobe, no repeat into T_HRS
        goto_state(1);
        mode_btn = 1'b1;
        adv_btn = 1'b1;
        acc = 5'd0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            acc |= stb;
            if (i == 5) mode_btn = 1'b0;
            if (i == 6) check("both_mode", 8'(mode), 8'd2);
        end
        check("both_no_strobe", 8'(acc), 8'd0);
        adv_btn = 1'b0;
        ticks(8);

        // Random button activity against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 3) == 0) adv_btn = ~adv_btn;
            tick();
        end

        // Auto-repeat in A_MIN: adv held 10 cycles
        goto_state(6);
        adv_btn = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            check("amin_alarmset", 8'(alarmset), 8'd1);
            check($sformatf("amin_minadv_c%0d", i), 8'(minadv),
                  8'((i == 6) || (i >= 8 && i <= 15)));
            if (i == 10) adv_btn = 1'b0;
        end
        ticks(4);

        // Reset mid-repeat in T_DATE, with mode held through reset
        goto_state(4);
        adv_btn = 1'b1;
        ticks(9);
        check("date_repeat", 8'(datadv), 8'd1);
        rst = 1'b1;
        mode_btn = 1'b1;
        #1;
        check("rst_mode", 8'(mode), 8'd0);
        check("rst_datadv", 8'(datadv), 8'd0);
        check("rst_outs", 8'({timeset, alarmset, stb}), 8'd0);
        ticks(2);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) check("post_rst_lat5", 8'(mode), 8'd0);
            if (i == 6) check("post_rst_lat6", 8'(mode), 8'd1);
        end
        mode_btn = 1'b0;
        adv_btn = 1'b0;
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
